// File: rtl/fetch_unit.sv
// Instruction fetch, next-PC selection and IF/ID register for the 16-bit core.
// Taken jr/jump/branch in ID redirects the PC and squashes the two wrong-path words.
module fetch_unit #(
    parameter int PC_W     = 12,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch,
    input  logic            zero,
    input  logic            jump,
    input  logic            jal,
    input  logic            jr,
    input  logic [15:0]     jr_addr,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     id_instr,
    output logic [PC_W-1:0] id_pc,
    output logic            id_valid,
    output logic [PC_W-1:0] link_addr,
    output logic            link_we,
    output logic            flush
);

    localparam logic [PC_W-1:0] ONE    = PC_W'(1);
    localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

    logic [PC_W-1:0] r_pc_q;
    logic [PC_W-1:0] r_if_pc;
    logic            r_if_valid;
    logic [15:0]     r_id_instr;
    logic [PC_W-1:0] r_id_pc;
    logic            r_id_valid;

    logic [15:0]     w_br_off;
    logic [15:0]     w_jfield;
    logic [PC_W-1:0] w_br_tgt;
    logic [PC_W-1:0] w_jump_tgt;
    logic [PC_W-1:0] w_jr_tgt;
    logic [PC_W-1:0] w_target;
    logic            w_taken;
    logic            w_unused;

    assign w_br_off   = {{8{r_id_instr[7]}}, r_id_instr[7:0]};
    assign w_jfield   = {4'h0, r_id_instr[11:0]};
    assign w_br_tgt   = r_id_pc + ONE + w_br_off[PC_W-1:0];
    assign w_jump_tgt = w_jfield[PC_W-1:0];
    assign w_jr_tgt   = jr_addr[PC_W-1:0];
    // Upper address bits beyond PC_W are intentionally dropped.
    assign w_unused   = ^{jr_addr, w_br_off, w_jfield};

    assign w_taken = r_id_valid & ~stall & (jr | jump | (branch & zero));

    always_comb begin
        w_target = w_br_tgt;
        if (jr) begin
            w_target = w_jr_tgt;
        end else if (jump) begin
            w_target = w_jump_tgt;
        end
    end

    // On stall the in-flight word is re-read so it is still on imem_rdata when stall drops.
    assign imem_addr = stall ? r_if_pc : r_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_q     <= RST_PC;
            r_if_pc    <= '0;
            r_if_valid <= 1'b0;
            r_id_instr <= 16'h0000;
            r_id_pc    <= '0;
            r_id_valid <= 1'b0;
        end else if (!stall) begin
            r_id_instr <= imem_rdata;
            r_id_pc    <= r_if_pc;
            r_if_pc    <= r_pc_q;
            if (w_taken) begin
                r_pc_q     <= w_target;
                r_id_valid <= 1'b0;
                r_if_valid <= 1'b0;
            end else begin
                r_pc_q     <= r_pc_q + ONE;
                r_id_valid <= r_if_valid;
                r_if_valid <= 1'b1;
            end
        end
    end

    assign id_instr  = r_id_instr;
    assign id_pc     = r_id_pc;
    assign id_valid  = r_id_valid;
    assign link_addr = r_id_pc + ONE;
    assign link_we   = r_id_valid & jal & ~stall;
    assign flush     = w_taken;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, branch/jal/jr redirects,
// stalls, address wrap and asynchronous reset during a redirect.
module tb_fetch_unit;

    localparam int PC_W = 12;
    localparam logic [3:0] OP_ALU = 4'h1;
    localparam logic [3:0] OP_J   = 4'h2;
    localparam logic [3:0] OP_JAL = 4'h3;
    localparam logic [3:0] OP_BEQ = 4'h4;
    localparam logic [3:0] OP_JR  = 4'h5;

    logic            clk;
    logic            rst_n;
    logic            stall;
    logic            branch;
    logic            zero;
    logic            jump;
    logic            jal;
    logic            jr;
    logic [15:0]     jr_addr;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_rdata;
    logic [15:0]     id_instr;
    logic [PC_W-1:0] id_pc;
    logic            id_valid;
    logic [PC_W-1:0] link_addr;
    logic            link_we;
    logic            flush;

    logic [15:0] mem [0:(1<<PC_W)-1];
    logic [3:0]  dec_op;

    int n_pass;
    int n_total;

    fetch_unit #(.PC_W(PC_W), .RESET_PC(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .branch    (branch),
        .zero      (zero),
        .jump      (jump),
        .jal       (jal),
        .jr        (jr),
        .jr_addr   (jr_addr),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .id_instr  (id_instr),
        .id_pc     (id_pc),
        .id_valid  (id_valid),
        .link_addr (link_addr),
        .link_we   (link_we),
        .flush     (flush)
    );

    // Clock and synchronous instruction memory
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) imem_rdata <= mem[imem_addr];

    // Decoder model: decodes whatever sits in ID, valid or not
    assign dec_op = id_instr[15:12];
    assign branch = (dec_op == OP_BEQ);
    assign jump   = (dec_op == OP_J) || (dec_op == OP_JAL);
    assign jal    = (dec_op == OP_JAL);
    assign jr     = (dec_op == OP_JR);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_id(input string tag, input logic v, input logic [PC_W-1:0] pc);
        check({tag, "_valid"}, 32'(id_valid), 32'(v));
        if (v) check({tag, "_pc"}, 32'(id_pc), 32'(pc));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_prog(input bit wrap_entry);
        for (int i = 0; i < (1 << PC_W); i++) mem[i] = {OP_ALU, 12'(i)};
        mem[5]      = {OP_BEQ, 4'h0, 8'hFC};
        mem[10]     = {OP_JAL, 12'h040};
        mem[11]     = {OP_J,   12'h800};
        mem[12]     = {OP_JR,  12'h000};
        mem[12'h042] = {OP_JR, 12'h000};
        mem[12'hFFF] = {OP_BEQ, 4'h0, 8'h01};
        if (wrap_entry) mem[0] = {OP_J, 12'hFFD};
    endtask

    // Holds reset for two negedges, checks reset state, releases at a negedge (cycle 0)
    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        zero  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_imem_addr", 32'(imem_addr), 32'h0);
        check("rst_id_valid", 32'(id_valid), 32'h0);
        check("rst_id_instr", 32'(id_instr), 32'h0);
        check("rst_id_pc", 32'(id_pc), 32'h0);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_link_we", 32'(link_we), 32'h0);
        rst_n = 1'b1;
        #1;
        check("c0_imem_addr", 32'(imem_addr), 32'h0);
        check("c0_id_valid", 32'(id_valid), 32'h0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        stall   = 1'b0;
        zero    = 1'b0;
        jr_addr = 16'h0123;

        // Sequential fetch, not-taken BEQ, JAL, JR
        load_prog(1'b0);
        do_reset();
        step();
        check("c1_imem_addr", 32'(imem_addr), 32'h1);
        chk_id("c1", 1'b0, 12'h0);
        step();
        chk_id("c2", 1'b1, 12'h0);
        check("c2_instr", 32'(id_instr), 32'h1000);
        check("c2_link_we", 32'(link_we), 32'h0);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk_id("seq", 1'b1, 12'(k));
            check("seq_flush", 32'(flush), 32'h0);
            check("seq_imem_addr", 32'(imem_addr), 32'(k + 2));
        end
        step();
        chk_id("jal", 1'b1, 12'd10);
        check("jal_flush", 32'(flush), 32'h1);
        check("jal_link_we", 32'(link_we), 32'h1);
        check("jal_link_addr", 32'(link_addr), 32'd11);
        step();
        chk_id("jal_b1", 1'b0, 12'h0);
        check("jal_b1_imem_addr", 32'(imem_addr), 32'h040);
        check("jal_b1_flush", 32'(flush), 32'h0);
        check("jal_b1_link_we", 32'(link_we), 32'h0);
        step();
        chk_id("jal_b2", 1'b0, 12'h0);
        check("jal_b2_flush", 32'(flush), 32'h0);
        step();
        chk_id("jal_tgt", 1'b1, 12'h040);
        step();
        chk_id("jal_tgt1", 1'b1, 12'h041);
        step();
        chk_id("jr", 1'b1, 12'h042);
        check("jr_flush", 32'(flush), 32'h1);
        check("jr_link_we", 32'(link_we), 32'h0);
        step();
        chk_id("jr_b1", 1'b0, 12'h0);
        step();
        chk_id("jr_b2", 1'b0, 12'h0);
        step();
        chk_id("jr_tgt", 1'b1, 12'h123);
        check("jr_tgt_instr", 32'(id_instr), 32'h1123);

        // Stalls: plain instruction, then a taken BEQ held in ID
        do_reset();
        zero = 1'b1;
        repeat (5) step();
        chk_id("s_c5", 1'b1, 12'd3);
        stall = 1'b1;
        #1;
        check("s_imem_addr", 32'(imem_addr), 32'd4);
        for (int k = 0; k < 2; k++) begin
            step();
            chk_id("s_hold", 1'b1, 12'd3);
            check("s_hold_instr", 32'(id_instr), 32'h1003);
            check("s_hold_imem_addr", 32'(imem_addr), 32'd4);
        end
        stall = 1'b0;
        #1;
        check("s_rel_imem_addr", 32'(imem_addr), 32'd5);
        step();
        chk_id("s_next", 1'b1, 12'd4);
        check("s_next_instr", 32'(id_instr), 32'h1004);
        step();
        chk_id("sb", 1'b1, 12'd5);
        check("sb_flush_pre", 32'(flush), 32'h1);
        stall = 1'b1;
        #1;
        check("sb_flush_stall", 32'(flush), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_id("sb_hold", 1'b1, 12'd5);
            check("sb_hold_flush", 32'(flush), 32'h0);
            check("sb_hold_imem_addr", 32'(imem_addr), 32'd6);
        end
        stall = 1'b0;
        #1;
        check("sb_rel_flush", 32'(flush), 32'h1);
        check("sb_rel_imem_addr", 32'(imem_addr), 32'd7);
        step();
        chk_id("sb_b1", 1'b0, 12'h0);
        check("sb_b1_imem_addr", 32'(imem_addr), 32'd2);
        step();
        chk_id("sb_b2", 1'b0, 12'h0);
        step();
        chk_id("sb_tgt", 1'b1, 12'd2);
        check("sb_tgt_instr", 32'(id_instr), 32'h1002);
        zero = 1'b0;
        step();
        chk_id("sb_tgt1", 1'b1, 12'd3);

        // Address wrap: sequential past 0xFFF, branch from 0xFFF with +1
        load_prog(1'b1);
        do_reset();
        step();
        step();
        check("w_j_flush", 32'(flush), 32'h1);
        step();
        check("w_b1_imem_addr", 32'(imem_addr), 32'hFFD);
        step();
        step();
        chk_id("w_ffd", 1'b1, 12'hFFD);
        step();
        step();
        chk_id("w_fff", 1'b1, 12'hFFF);
        check("w_fff_flush", 32'(flush), 32'h0);
        check("w_fff_imem_addr", 32'(imem_addr), 32'h001);
        step();
        chk_id("w_wrap", 1'b1, 12'h000);
        check("w_wrap_flush", 32'(flush), 32'h1);
        repeat (5) step();
        chk_id("w_fff2", 1'b1, 12'hFFF);
        zero = 1'b1;
        #1;
        check("w_br_flush", 32'(flush), 32'h1);
        step();
        chk_id("w_br_b1", 1'b0, 12'h0);
        check("w_br_b1_flush", 32'(flush), 32'h0);
        check("w_br_b1_imem_addr", 32'(imem_addr), 32'h001);
        step();
        step();
        chk_id("w_br_tgt", 1'b1, 12'h001);
        zero = 1'b0;

        // Asynchronous reset in the middle of a redirect cycle
        do_reset();
        step();
        step();
        check("ar_flush_pre", 32'(flush), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_flush", 32'(flush), 32'h0);
        check("ar_id_valid", 32'(id_valid), 32'h0);
        check("ar_imem_addr", 32'(imem_addr), 32'h0);
        check("ar_link_addr", 32'(link_addr), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ar_c0_imem_addr", 32'(imem_addr), 32'h0);
        step();
        check("ar_c1_imem_addr", 32'(imem_addr), 32'h1);
        chk_id("ar_c1", 1'b0, 12'h0);
        step();
        chk_id("ar_c2", 1'b1, 12'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and next-PC unit for the 16-bit single-issue core.
- Consumes the decoder's branch/jump/jal/jr outputs and the ALU zero flag, i.e. the consuming end of the control-signal interface.
- Drives a synchronous instruction memory and owns the IF/ID register (instruction, PC, valid).
- Redirects on taken control transfers, squashes wrong-path fetches and holds on stall.

Parameters:
- PC_W, 12, PC/instruction-address width in words; legal range 8..16.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hazard stall; hold IF/ID and PC
- branch  in  1  decoder: ID instruction is BEQ
- zero  in  1  ALU equality result for ID instruction
- jump  in  1  decoder: ID instruction is J or JAL
- jal  in  1  decoder: ID instruction is JAL (link)
- jr  in  1  decoder: ID instruction is JR
- jr_addr  in  16  register value for JR target
- imem_addr  out  PC_W  instruction memory address; data returns next cycle
- imem_rdata  in  16  instruction memory read data
- id_instr  out  16  IF/ID instruction, to decoder (opcode = [15:12])
- id_pc  out  PC_W  PC of id_instr
- id_valid  out  1  id_instr is a real instruction, not a bubble
- link_addr  out  PC_W  id_pc+1, write data for JAL
- link_we  out  1  id_valid & jal & ~stall
- flush  out  1  redirect taken this cycle

Behaviour:
- Reset (async, rst_n=0):
  - pc_q=RESET_PC, if_pc=0, if_valid=0.
  - id_instr=16'h0000, id_pc=0, id_valid=0.
  - flush=0, link_we=0.
- Fetch pipeline:
  - pc_q is the address issued this cycle.
  - if_pc/if_valid track the address issued last cycle, whose data is on imem_rdata now.
- imem_addr: if_pc when stall=1 (re-read the in-flight word), otherwise pc_q.
- Targets (all arithmetic modulo 2^PC_W, wrap silently):
  - branch target = id_pc + 1 + sign-extended id_instr[7:0].
  - jump target = id_instr[11:0] zero-extended or truncated to PC_W.
  - jr target = jr_addr[PC_W-1:0].
- taken = id_valid & ~stall & (jr | jump | (branch & zero)).
  - Priority when several are asserted: jr > jump > branch.
  - flush = taken (combinational).
- Normal cycle (stall=0, taken=0):
  - id_instr<=imem_rdata, id_pc<=if_pc, id_valid<=if_valid.
  - if_pc<=pc_q, if_valid<=1, pc_q<=pc_q+1.
- Redirect cycle (taken=1):
  - pc_q<=target, id_valid<=0, if_valid<=0.
  - Both wrong-path words (ID+1 and ID+2) are squashed: 2 bubble cycles, target reaches ID 2 cycles after the redirect edge.
  - id_instr is still loaded, but is don't-care while invalid.
- Stall cycle (stall=1):
  - pc_q, if_pc, if_valid, id_* are all held.
  - Redirect is suppressed; it is re-evaluated when stall drops.
  - Memory is re-read at if_pc, so no word is lost; any stall length is legal.
- Control inputs are ignored when id_valid=0: no flush, no link_we.
- link_addr = id_pc+1 at all times; link_we gates its use.
- First valid ID instruction appears 2 cycles after rst_n rises (RESET_PC).
- Reset asserted mid-redirect or mid-stall: immediate return to reset state, with no pending redirect retained.
- No combinational path from imem_rdata to imem_addr.

Test Plan:
- Reset, RESET_PC=0, memory holds sequential ALU ops -> imem_addr 0,1,2,3…; id_valid rises in cycle 2 with id_pc=0, then increments by 1 each cycle; link_we=0.
- BEQ at addr 5, imm=8'hFC, zero=1 -> flush=1 one cycle; next valid id_pc=2 after exactly 2 bubbles. With zero=0 -> no flush, id_pc 6 follows.
- JAL at addr 10, target field 12'h040 -> link_we=1 with link_addr=11 in that cycle; next valid id_pc=0x040. JR with jr_addr=16'h0123 -> next valid id_pc=0x123.
- stall held 3 cycles while a BEQ-taken is in ID -> id_*/pc_q frozen, flush=0 throughout. Stall drops -> flush=1, redirect occurs, no instruction duplicated or skipped.
- Branch at PC 0xFFF, imm=+1 (PC_W=12) -> target 0x001 (wrap). Sequential fetch past 0xFFF -> 0x000.
- rst_n pulsed low asynchronously between edges during a redirect -> outputs reset immediately; refetch starts at RESET_PC with 2-cycle fill.
